rep_move_master: RTL and testbench

- Block-move initiator that drives the simulation memory port (addr / wr_data / rd_data / we / byte_m) from the master side.
- Executes x86 REP MOVSB/MOVSW semantics: read element at source, write it to destination, step both pointers, decrement count.
- Sits between the core's string-op sequencer and the memory port.
- Provides a stand-alone stimulus engine for repeat-prefix tests.

---
 rtl/rep_move_pkg.sv | 24 ++
 rtl/rep_addr_step.sv | 26 ++
 rtl/rep_move_master.sv | 194 +++++++++++++++++++
 tb/tb_rep_move_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rep_move_pkg.sv
// rep_move_pkg
//   Types and constants shared by the repeat-string move master and its
//   address stepper: the FSM state encoding, default address and count
//   widths, and the element step sizes.
package rep_move_pkg;

  localparam int AW_DEF    = 20;  // 1 MB byte-addressed space
  localparam int CW_DEF    = 16;  // CX-sized element counter
  localparam int STEP_BYTE = 1;
  localparam int STEP_WORD = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Pointer increment for one element of the selected size.
  function automatic logic [1:0] step_size(input logic byte_op);
    return byte_op ? 2'(STEP_BYTE) : 2'(STEP_WORD);
  endfunction

endpackage

// File: rtl/rep_addr_step.sv
// rep_addr_step
//   Combinational pointer stepper: next = addr +/- (1 or 2), modulo 2^AW,
//   so the address naturally wraps at both ends of the space.
// Ports:
//   addr      - current pointer
//   byte_op   - 1 = step by one byte, 0 = step by one word
//   df        - direction: 0 = increment, 1 = decrement
//   next_addr - stepped pointer
module rep_addr_step
  import rep_move_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] addr,
  input  logic          byte_op,
  input  logic          df,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] step;

  assign step      = {{(AW-2){1'b0}}, step_size(byte_op)};
  // Plain AW-bit add/subtract discards the carry, giving modulo-2^AW wrap.
  assign next_addr = df ? (addr - step) : (addr + step);

endmodule

// File: rtl/rep_move_master.sv
// rep_move_master
//   REP MOVSB/MOVSW block-move initiator driving a byte-addressed memory
//   port. Each element is read from the source pointer and written to the
//   destination pointer (two cycles per element), then both pointers step
//   and the remaining count (CX shadow) decrements.
//
//   Optional build macro REP_MOVE_FILL_EN adds fill / fill_data inputs:
//   with fill=1 the read is skipped and fill_data is stored at every
//   destination element (STOS semantics, one cycle per element).
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - one-cycle request, honoured only in IDLE
//   src_addr        - first source byte address
//   dst_addr        - first destination byte address
//   count           - number of elements to move
//   byte_op         - 1 = bytes, 0 = 16-bit words
//   df              - direction flag, 0 = up, 1 = down
//   busy            - transfer in progress
//   done            - one-cycle completion pulse
//   remaining       - elements still to move
//   mem_addr        - memory address
//   mem_wr_data     - memory write data
//   mem_rd_data     - combinational memory read data
//   mem_we          - memory write enable (committed at next posedge)
//   mem_byte_m      - memory access size, latched byte_op
module rep_move_master
  import rep_move_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef REP_MOVE_FILL_EN
  input  logic          fill,
  input  logic [15:0]   fill_data,
`endif
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [CW-1:0] count,
  input  logic          byte_op,
  input  logic          df,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] remaining,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wr_data,
  input  logic [15:0]   mem_rd_data,
  output logic          mem_we,
  output logic          mem_byte_m
);

  state_t        state;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic          df_q;
  logic          fill_q;
  logic [AW-1:0] src_next;
  logic [AW-1:0] dst_next;
  logic [CW-1:0] remaining_next;
  logic          start_fill;
  logic [15:0]   start_fill_data;

`ifdef REP_MOVE_FILL_EN
  assign start_fill      = fill;
  assign start_fill_data = fill_data;
`else
  assign start_fill      = 1'b0;
  assign start_fill_data = 16'h0000;
`endif

  assign remaining_next = remaining - {{(CW-1){1'b0}}, 1'b1};

  rep_addr_step #(.AW(AW)) u_src_step (
    .addr      (src_q),
    .byte_op   (mem_byte_m),
    .df        (df_q),
    .next_addr (src_next)
  );

  rep_addr_step #(.AW(AW)) u_dst_step (
    .addr      (dst_q),
    .byte_op   (mem_byte_m),
    .df        (df_q),
    .next_addr (dst_next)
  );

  // Transfer FSM; every memory-port output is registered and is loaded on
  // the edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      df_q        <= 1'b0;
      fill_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      remaining   <= '0;
      mem_addr    <= '0;
      mem_wr_data <= 16'h0000;
      mem_we      <= 1'b0;
      mem_byte_m  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mem_addr    <= '0;
          mem_wr_data <= 16'h0000;
          mem_we      <= 1'b0;
          busy        <= 1'b0;
          if (start) begin
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            df_q       <= df;
            fill_q     <= start_fill;
            mem_byte_m <= byte_op;
            remaining  <= count;
            if (count == '0) begin
              // Empty move: straight to completion, no memory traffic.
              state <= FIN;
            end else if (start_fill) begin
              state       <= WRITE;
              busy        <= 1'b1;
              mem_addr    <= dst_addr;
              mem_wr_data <= start_fill_data;
              mem_we      <= 1'b1;
            end else begin
              state    <= READ;
              busy     <= 1'b1;
              mem_addr <= src_addr;
            end
          end else begin
            state <= IDLE;
          end
        end

        READ: begin
          // Read data is sampled here and presented as write data; the
          // upper byte of a sign-extended byte read is passed unchanged.
          mem_wr_data <= mem_rd_data;
          mem_addr    <= dst_q;
          mem_we      <= 1'b1;
          state       <= WRITE;
        end

        WRITE: begin
          dst_q     <= dst_next;
          remaining <= remaining_next;
          if (!fill_q) begin
            src_q <= src_next;
          end else begin
            src_q <= src_q;
          end
          if (remaining_next == '0) begin
            state       <= FIN;
            busy        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= 16'h0000;
            mem_we      <= 1'b0;
          end else if (fill_q) begin
            // Fill keeps the same write data and only walks the destination.
            state    <= WRITE;
            mem_addr <= dst_next;
            mem_we   <= 1'b1;
          end else begin
            state       <= READ;
            mem_addr    <= src_next;
            mem_wr_data <= 16'h0000;
            mem_we      <= 1'b0;
          end
        end

        FIN: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          mem_addr    <= '0;
          mem_wr_data <= 16'h0000;
          mem_we      <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rep_move_master.sv
// tb_rep_move_master
//   Directed and randomized block moves against a byte-array memory model.
//   A reference model replays each move element by element on a shadow
//   memory and predicts the read/write address sequences and latency.
module tb_rep_move_master;

  localparam int AW = 20;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [CW-1:0] count;
  logic          byte_op;
  logic          df;
  logic          busy;
  logic          done;
  logic [CW-1:0] remaining;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wr_data;
  logic [15:0]   mem_rd_data;
  logic          mem_we;
  logic          mem_byte_m;
`ifdef REP_MOVE_FILL_EN
  logic          fill = 1'b0;
  logic [15:0]   fill_data = 16'h0000;
`endif

  rep_move_master #(.AW(AW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef REP_MOVE_FILL_EN
    .fill        (fill),
    .fill_data   (fill_data),
`endif
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .count       (count),
    .byte_op     (byte_op),
    .df          (df),
    .busy        (busy),
    .done        (done),
    .remaining   (remaining),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_we      (mem_we),
    .mem_byte_m  (mem_byte_m)
  );

  always #5 clk = ~clk;

  // Memory model and traffic logs
  logic [7:0]    mem     [0:(1<<AW)-1];
  logic [7:0]    ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] mem_addr_p1;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log[$];
  int            busy_cycles = 0;
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [7:0]    poke_data = 8'h00;

  assign mem_addr_p1 = mem_addr + 20'd1;
  assign mem_rd_data = mem_byte_m ? {{8{mem[mem_addr][7]}}, mem[mem_addr]}
                                  : {mem[mem_addr_p1], mem[mem_addr]};

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wr_data[7:0];
      if (!mem_byte_m) mem[mem_addr_p1] <= mem_wr_data[15:8];
      wr_log.push_back(mem_addr);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
    if (busy && !mem_we) rd_log.push_back(mem_addr);
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    @(negedge clk);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] exp_wr[$];

  // Reference: x86 string move applied one element at a time to ref_mem.
  task automatic model_move(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int n, input bit bo, input bit dir);
    int step;
    logic [15:0] v;
    step = bo ? 1 : 2;
    exp_rd.delete();
    exp_wr.delete();
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(s);
      exp_wr.push_back(d);
      v = bo ? {8'h00, ref_mem[s]} : {ref_mem[AW'(s + 1)], ref_mem[s]};
      ref_mem[d] = v[7:0];
      if (!bo) ref_mem[AW'(d + 1)] = v[15:8];
      s = dir ? AW'(s - step) : AW'(s + step);
      d = dir ? AW'(d - step) : AW'(d + step);
    end
  endtask

  task automatic run_move(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input int n, input bit bo, input bit dir, input bit poke_start);
    int rb, wb, bb, k;
    logic [AW-1:0] a;
    rb = rd_log.size();
    wb = wr_log.size();
    bb = busy_cycles;
    model_move(s, d, n, bo, dir);
    @(negedge clk);
    src_addr = s; dst_addr = d; count = CW'(n); byte_op = bo; df = dir; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    check({tag, " busy_first"}, {31'd0, busy}, {31'd0, (n != 0)});
    while (!done && k < 2 * n + 20) begin
      if (n > 0 && (k % 2) == 1 && k < 2 * n)
        check({tag, " remaining"}, {16'd0, remaining}, 32'(n - (k - 1) / 2));
      if (poke_start && k == 3) begin
        start = 1'b1; src_addr = ~s; count = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(k), 32'(2 * n + 2));
    check({tag, " remaining_end"}, {16'd0, remaining}, 32'd0);
    check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, " addr_idle"}, {12'd0, mem_addr}, 32'd0);
    check({tag, " byte_m"}, {31'd0, mem_byte_m}, {31'd0, bo});
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, " busy_cycles"}, 32'(busy_cycles - bb), 32'(2 * n));
    check({tag, " n_reads"}, 32'(rd_log.size() - rb), 32'(n));
    check({tag, " n_writes"}, 32'(wr_log.size() - wb), 32'(n));
    for (int i = 0; i < n && rb + i < rd_log.size() && wb + i < wr_log.size(); i++) begin
      check({tag, " rd_addr"}, {12'd0, rd_log[rb + i]}, {12'd0, exp_rd[i]});
      check({tag, " wr_addr"}, {12'd0, wr_log[wb + i]}, {12'd0, exp_wr[i]});
      a = exp_wr[i];
      check({tag, " data_lo"}, {24'd0, mem[a]}, {24'd0, ref_mem[a]});
      if (!bo) check({tag, " data_hi"}, {24'd0, mem[AW'(a + 1)]}, {24'd0, ref_mem[AW'(a + 1)]});
    end
  endtask

  initial begin
    int n, wb0, wb1;
    logic [AW-1:0] s, d;
    bit bo, dir;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; count = '0; byte_op = 1'b0; df = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst remaining", {16'd0, remaining}, 32'd0);
    check("rst we", {31'd0, mem_we}, 32'd0);
    check("rst addr", {12'd0, mem_addr}, 32'd0);
    check("rst wdata", {16'd0, mem_wr_data}, 32'd0);
    check("rst byte_m", {31'd0, mem_byte_m}, 32'd0);
    rst = 1'b0;

    // Byte forward
    poke(20'h00100, 8'h11); poke(20'h00101, 8'h22); poke(20'h00102, 8'h33); poke(20'h00103, 8'h44);
    run_move("byte_fwd", 20'h00100, 20'h00200, 4, 1'b1, 1'b0, 1'b0);
    check("byte_fwd m200", {24'd0, mem[20'h00200]}, 32'h11);
    check("byte_fwd m203", {24'd0, mem[20'h00203]}, 32'h44);

    // Word backward
    poke(20'h00300, 8'hAA); poke(20'h00301, 8'hAA); poke(20'h00302, 8'hBB); poke(20'h00303, 8'hBB);
    run_move("word_bwd", 20'h00302, 20'h00402, 2, 1'b0, 1'b1, 1'b0);
    check("word_bwd m402", {16'd0, mem[20'h00403], mem[20'h00402]}, 32'hBBBB);
    check("word_bwd m400", {16'd0, mem[20'h00401], mem[20'h00400]}, 32'hAAAA);

    // Empty move, with a start pulse ignored mid-transfer in a later move
    run_move("count0", 20'h00100, 20'h00900, 0, 1'b1, 1'b0, 1'b0);

    // Word copy wrapping past the top of the address space
    poke(20'hFFFFE, 8'h01); poke(20'hFFFFF, 8'h02); poke(20'h00000, 8'h03); poke(20'h00001, 8'h04);
    run_move("wrap_word", 20'hFFFFE, 20'h00800, 2, 1'b0, 1'b0, 1'b0);
    check("wrap_word m802", {16'd0, mem[20'h00803], mem[20'h00802]}, 32'h0403);

    // Forward overlap replicates the first byte
    poke(20'h00500, 8'h5A);
    run_move("overlap", 20'h00500, 20'h00501, 3, 1'b1, 1'b0, 1'b0);
    check("overlap m501", {24'd0, mem[20'h00501]}, 32'h5A);
    check("overlap m503", {24'd0, mem[20'h00503]}, 32'h5A);

    // Byte backward with destination wrapping below zero
    poke(20'h00010, 8'hC1); poke(20'h0000F, 8'h7E); poke(20'h0000E, 8'h80); poke(20'h0000D, 8'h09);
    run_move("bwd_wrap", 20'h00010, 20'h00001, 4, 1'b1, 1'b1, 1'b0);
    check("bwd_wrap mFFFFF", {24'd0, mem[20'hFFFFF]}, 32'h80);

    // Randomized moves
    for (int t = 0; t < 8; t++) begin
      s   = 20'($urandom);
      d   = 20'($urandom);
      n   = $urandom_range(1, 8);
      bo  = 1'($urandom);
      dir = 1'($urandom);
      for (int j = -8; j <= 8; j++) poke(AW'(s + j), 8'($urandom));
      run_move("random", s, d, n, bo, dir, (t == 2) || (t == 5));
    end

    // Reset during the write of element 2 of 4
    @(negedge clk);
    src_addr = 20'h00900; dst_addr = 20'h00A00; count = 16'd4; byte_op = 1'b1; df = 1'b0; start = 1'b1;
    wb0 = wr_log.size();
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid we_before", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid we", {31'd0, mem_we}, 32'd0);
    check("rst_mid busy", {31'd0, busy}, 32'd0);
    check("rst_mid remaining", {16'd0, remaining}, 32'd0);
    check("rst_mid addr", {12'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    wb1 = wr_log.size();
    repeat (12) begin
      @(negedge clk);
      check("rst_mid no_done", {31'd0, done}, 32'd0);
    end
    check("rst_mid no_writes", 32'(wr_log.size() - wb1), 32'd0);
    check("rst_mid total_writes", 32'(wb1 - wb0), 32'd2);
    check("rst_mid busy_after", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
